// File: rtl/csr_rmw_ctrl_pkg.sv
// Shared definitions for the CSR read-modify-write controller:
// Zicsr funct3 encodings, FSM state encoding and the idle bus address.
// Optional feature macro: CSR_RMW_SKIP_EN (see csr_rmw_ctrl_alu.sv).
package csr_rmw_ctrl_pkg;

  localparam logic [2:0] CSR_F3_RW  = 3'b001;
  localparam logic [2:0] CSR_F3_RS  = 3'b010;
  localparam logic [2:0] CSR_F3_RC  = 3'b011;
  localparam logic [2:0] CSR_F3_RWI = 3'b101;
  localparam logic [2:0] CSR_F3_RSI = 3'b110;
  localparam logic [2:0] CSR_F3_RCI = 3'b111;

  localparam logic [11:0] CSR_ADDR_IDLE = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RESP
  } state_t;

  // funct3 values 000 and 100 are not Zicsr ops; every other code is.
  function automatic logic isLegalF3(input logic [2:0] funct3);
    return funct3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_rmw_ctrl_if.sv
// Bundles the execute-side request/response handshake and the CSR file
// en/we/busy bus. 'master' is the controller's view, 'slave' is the
// view of whatever surrounds it (execute stage plus CSR file).
interface csr_rmw_ctrl_if #(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
);

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [2:0]                req_funct3_i;
  logic [CSR_ADDR_WIDTH-1:0] req_addr_i;
  logic [CSR_DATA_WIDTH-1:0] req_rs1_i;
  logic [4:0]                req_uimm_i;

  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [CSR_DATA_WIDTH-1:0] rsp_data_o;
  logic                      rsp_illegal_o;

  logic                      csr_en_o;
  logic                      csr_we_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_o;
  logic [CSR_DATA_WIDTH-1:0] csr_data_o;
  logic [CSR_DATA_WIDTH-1:0] csr_data_i;
  logic                      csr_busy_i;
  logic                      csr_exists_i;
  logic                      csr_ro_i;

  modport master (
    input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_i, req_uimm_i,
    input  rsp_ready_i,
    input  csr_data_i, csr_busy_i, csr_exists_i, csr_ro_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
    output csr_en_o, csr_we_o, csr_addr_o, csr_data_o
  );

  modport slave (
    output req_valid_i, req_funct3_i, req_addr_i, req_rs1_i, req_uimm_i,
    output rsp_ready_i,
    output csr_data_i, csr_busy_i, csr_exists_i, csr_ro_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_illegal_o,
    input  csr_en_o, csr_we_o, csr_addr_o, csr_data_o
  );

endinterface

// File: rtl/csr_rmw_ctrl_alu.sv
// Combinational new-value computation for a Zicsr op, plus the decision
// whether the write phase is needed at all.
// Optional feature macro: CSR_RMW_SKIP_EN -- when defined, set/clear forms
// with a zero operand skip the write; otherwise every legal op writes.
module csr_rmw_ctrl_alu
  import csr_rmw_ctrl_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic [2:0]                i_funct3,
  input  logic [CSR_DATA_WIDTH-1:0] i_old,
  input  logic [CSR_DATA_WIDTH-1:0] i_rs1,
  input  logic [4:0]                i_uimm,
  output logic [CSR_DATA_WIDTH-1:0] o_newVal,
  output logic                      o_writeReq
);

  logic [CSR_DATA_WIDTH-1:0] w_operand;

  assign w_operand = i_funct3[2] ? {{(CSR_DATA_WIDTH-5){1'b0}}, i_uimm} : i_rs1;

  // Merge the operand into the old value according to write/set/clear.
  always_comb begin
    o_newVal = i_old;
    case (i_funct3)
      CSR_F3_RW, CSR_F3_RWI: o_newVal = w_operand;
      CSR_F3_RS, CSR_F3_RSI: o_newVal = i_old | w_operand;
      CSR_F3_RC, CSR_F3_RCI: o_newVal = i_old & ~w_operand;
      default:               o_newVal = i_old;
    endcase
  end

`ifdef CSR_RMW_SKIP_EN
  // A set/clear with nothing to set or clear is a pure read.
  assign o_writeReq = (i_funct3[1:0] == 2'b01) || (w_operand != '0);
`else
  assign o_writeReq = 1'b1;
`endif

endmodule

// File: rtl/csr_rmw_ctrl.sv
// Converts one Zicsr instruction into a CSR read followed (when needed)
// by a CSR write, and returns the old value or an illegal flag.
// One instruction in flight at a time. Optional feature macro:
// CSR_RMW_SKIP_EN (write-phase skip for zero-operand set/clear).
module csr_rmw_ctrl
  import csr_rmw_ctrl_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int BUSY_TIMEOUT   = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_rmw_ctrl_if.master  bus
);

  localparam logic [7:0] CNT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t                    r_state;
  logic [2:0]                r_funct3;
  logic [CSR_DATA_WIDTH-1:0] r_rs1;
  logic [4:0]                r_uimm;
  logic [CSR_DATA_WIDTH-1:0] r_old;
  logic [7:0]                r_cnt;
  logic                      r_seenBusy;

  logic [CSR_DATA_WIDTH-1:0] w_newVal;
  logic                      w_writeReq;
  logic                      w_busyRise;
  logic                      w_busyFall;
  logic                      w_timeout;

  // The ALU sees the live read data so the write value is ready on the
  // same edge the read completes.
  csr_rmw_ctrl_alu #(
    .CSR_DATA_WIDTH(CSR_DATA_WIDTH)
  ) u_alu (
    .i_funct3  (r_funct3),
    .i_old     (bus.csr_data_i),
    .i_rs1     (r_rs1),
    .i_uimm    (r_uimm),
    .o_newVal  (w_newVal),
    .o_writeReq(w_writeReq)
  );

  assign w_busyRise = !r_seenBusy && bus.csr_busy_i;
  assign w_busyFall = r_seenBusy && !bus.csr_busy_i;
  assign w_timeout  = !w_busyRise && !w_busyFall && (r_cnt == CNT_LAST);

  // Controller FSM; every output is a register updated with the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= ST_IDLE;
      r_funct3          <= '0;
      r_rs1             <= '0;
      r_uimm            <= '0;
      r_old             <= '0;
      r_cnt             <= '0;
      r_seenBusy        <= 1'b0;
      bus.req_ready_o   <= 1'b1;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_data_o    <= '0;
      bus.rsp_illegal_o <= 1'b0;
      bus.csr_en_o      <= 1'b0;
      bus.csr_we_o      <= 1'b0;
      bus.csr_addr_o    <= CSR_ADDR_WIDTH'(CSR_ADDR_IDLE);
      bus.csr_data_o    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            r_funct3        <= bus.req_funct3_i;
            r_rs1           <= bus.req_rs1_i;
            r_uimm          <= bus.req_uimm_i;
            bus.req_ready_o <= 1'b0;
            if (!isLegalF3(bus.req_funct3_i)) begin
              r_state           <= ST_RESP;
              bus.rsp_valid_o   <= 1'b1;
              bus.rsp_illegal_o <= 1'b1;
              bus.rsp_data_o    <= '0;
            end else begin
              r_state        <= ST_RD_ISSUE;
              bus.csr_en_o   <= 1'b1;
              bus.csr_we_o   <= 1'b0;
              bus.csr_addr_o <= bus.req_addr_i;
            end
          end
        end

        ST_RD_ISSUE: begin
          bus.csr_en_o <= 1'b0;
          r_cnt        <= '0;
          r_seenBusy   <= 1'b0;
          r_state      <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (w_busyRise) begin
            r_seenBusy <= 1'b1;
            r_cnt      <= '0;
          end else if (w_busyFall) begin
            r_old          <= bus.csr_data_i;
            bus.csr_addr_o <= CSR_ADDR_WIDTH'(CSR_ADDR_IDLE);
            if (!bus.csr_exists_i || (w_writeReq && bus.csr_ro_i)) begin
              r_state           <= ST_RESP;
              bus.rsp_valid_o   <= 1'b1;
              bus.rsp_illegal_o <= 1'b1;
              bus.rsp_data_o    <= '0;
            end else if (w_writeReq) begin
              r_state        <= ST_WR_ISSUE;
              bus.csr_en_o   <= 1'b1;
              bus.csr_we_o   <= 1'b1;
              bus.csr_addr_o <= bus.csr_addr_o;
              bus.csr_data_o <= w_newVal;
            end else begin
              r_state           <= ST_RESP;
              bus.rsp_valid_o   <= 1'b1;
              bus.rsp_illegal_o <= 1'b0;
              bus.rsp_data_o    <= bus.csr_data_i;
            end
          end else if (w_timeout) begin
            r_state           <= ST_RESP;
            bus.csr_addr_o    <= CSR_ADDR_WIDTH'(CSR_ADDR_IDLE);
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_illegal_o <= 1'b1;
            bus.rsp_data_o    <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_WR_ISSUE: begin
          bus.csr_en_o <= 1'b0;
          bus.csr_we_o <= 1'b0;
          r_cnt        <= '0;
          r_seenBusy   <= 1'b0;
          r_state      <= ST_WR_WAIT;
        end

        ST_WR_WAIT: begin
          if (w_busyRise) begin
            r_seenBusy <= 1'b1;
            r_cnt      <= '0;
          end else if (w_busyFall || w_timeout) begin
            r_state           <= ST_RESP;
            bus.csr_addr_o    <= CSR_ADDR_WIDTH'(CSR_ADDR_IDLE);
            bus.csr_data_o    <= '0;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_illegal_o <= w_timeout;
            bus.rsp_data_o    <= w_timeout ? '0 : r_old;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            r_state           <= ST_IDLE;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_illegal_o <= 1'b0;
            bus.rsp_data_o    <= '0;
            bus.req_ready_o   <= 1'b1;
          end
        end

        default: begin
          r_state         <= ST_IDLE;
          bus.req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Sits between the execute stage and the CSR file, upstream of the CSR file.
- Turns one Zicsr instruction (CSRRW/S/C and their immediate forms) into a read transaction, then a write transaction, on the CSR file's en/we/busy interface.
- Returns the old CSR value for rd, or an illegal-instruction flag.
- Handles exactly one instruction at a time; there is no pipelining.

Parameters:
- CSR_DATA_WIDTH, 32, data width of CSR values and operands.
- CSR_ADDR_WIDTH, 12, width of a CSR address.
- BUSY_TIMEOUT, 15, maximum number of cycles to wait for busy to rise, or to fall, before aborting. Legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  instruction request from execute.
- req_ready_o  out  1  high only in IDLE.
- req_funct3_i  in  3  Zicsr funct3.
- req_addr_i  in  CSR_ADDR_WIDTH  CSR address.
- req_rs1_i  in  CSR_DATA_WIDTH  rs1 value.
- req_uimm_i  in  5  rs1 field, used as the zero-extended immediate.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  execute accepts the response.
- rsp_data_o  out  CSR_DATA_WIDTH  old CSR value.
- rsp_illegal_o  out  1  illegal op, read-only write, or timeout.
- csr_en_o  out  1  transaction start strobe to the CSR file.
- csr_we_o  out  1  write enable, qualified by csr_en_o.
- csr_addr_o  out  CSR_ADDR_WIDTH  CSR address.
- csr_data_o  out  CSR_DATA_WIDTH  write data.
- csr_data_i  in  CSR_DATA_WIDTH  CSR file read data.
- csr_busy_i  in  1  CSR file busy.
- csr_exists_i  in  1  address implemented.
- csr_ro_i  in  1  address is read-only.

Behaviour:
- Reset (synchronous, rst_i high):
  - state = IDLE.
  - All outputs 0, except req_ready_o = 1.
  - Holding registers cleared.
  - Reset mid-transaction abandons it; no response is produced.
- Handshake:
  - A request is accepted when req_valid_i & req_ready_o; all inputs are latched on that edge.
  - A response is retired when rsp_valid_o & rsp_ready_i.
  - rsp_valid_o, rsp_data_o and rsp_illegal_o hold stable until retired.
- Operand: op = funct3[2] ? {27'b0, uimm} : rs1.
- New value: RW gives op; RS gives old | op; RC gives old & ~op.
- csr_addr_o drives the latched address only in states RD_ISSUE through WR_WAIT; elsewhere it is 12'h000.
- csr_data_o equals the new value in WR_ISSUE and WR_WAIT, and 0 otherwise.
- States:
  - IDLE: on accept, funct3 000 or 100 goes to RESP with illegal = 1. Otherwise go to RD_ISSUE.
  - RD_ISSUE: one cycle with csr_en_o = 1 and csr_we_o = 0. Then RD_WAIT.
  - RD_WAIT:
    - Waits for csr_busy_i to rise, then fall.
    - In the first cycle where busy = 0 after having been 1, sample csr_data_i into old, and sample csr_exists_i and csr_ro_i.
    - If !exists, go to RESP with illegal = 1.
    - If a write is required and ro, go to RESP with illegal = 1.
    - If a write is required, go to WR_ISSUE; otherwise go to RESP.
  - WR_ISSUE: one cycle with csr_en_o = 1 and csr_we_o = 1. Then WR_WAIT.
  - WR_WAIT: same busy rise/fall wait as RD_WAIT. Then RESP.
  - RESP: rsp_valid_o = 1 and rsp_data_o = old. On retire, go to IDLE.
- Illegal responses drive rsp_data_o = 0.
- Timeout:
  - An 8-bit counter clears on entry to each WAIT state and increments each cycle.
  - If busy fails to rise, or fails to fall, within BUSY_TIMEOUT cycles, go to RESP with illegal = 1.
- Nominal latency, accept to rsp_valid_o, with a 1-cycle-busy CSR file: 7 cycles with write, 4 cycles without.
- A write is required when the op is RW/RWI, or when the op is RS/RC/RSI/RCI and the operand is nonzero (RS/RC) or the immediate is nonzero (RSI/RCI). This rule assumes CSR_RMW_SKIP_EN is defined; see Optional Feature.
- A req_valid_i arriving while the response is pending is not accepted.

Optional Feature:
- Macro: CSR_RMW_SKIP_EN.
- Defined: set/clear forms with a zero rs1 operand or zero immediate skip WR_ISSUE/WR_WAIT, are never checked against ro, and read-only CSRs are readable through them.
- Undefined: every legal op performs the write phase. Set/clear forms with a zero operand or zero immediate therefore rewrite the old value, and are flagged illegal on read-only CSRs.

Decomposition:
- Shared header cpu/csrdefs.vh holds:
  - funct3 encodings CSR_F3_RW/RS/RC/RWI/RSI/RCI;
  - state encodings;
  - CSR_ADDR_IDLE = 12'h000.
- Natural sub-module: csr_rmw_alu, combinational. Inputs funct3, old, rs1, uimm; outputs new value and write-required flag.

Test Plan:
- CSRRW 0x340 with rs1 = 0xDEADBEEF, old = 0x12345678 -> read then write, csr_data_o = 0xDEADBEEF, rsp_data_o = 0x12345678, latency 7.
- CSRRS 0x300 with rs1 = 0x8, old = 0x1 -> write 0x9, rsp 0x1. CSRRC with rs1 = 0x1, old = 0x9 -> write 0x8.
- CSRRSI with uimm = 0 on a read-only CSR (ro = 1), old = 0xABCD -> with the macro: no write, rsp 0xABCD, illegal = 0, latency 4. Without the macro: illegal = 1.
- funct3 = 100 -> no csr_en_o, rsp_illegal_o = 1 one cycle after accept. Address with exists = 0 -> illegal, no write.
- csr_busy_i stuck 0 after RD_ISSUE -> illegal after BUSY_TIMEOUT cycles. rsp_ready_i held 0 for 5 cycles -> response held stable, req_ready_o stays 0.
- rst_i asserted during WR_WAIT -> next cycle IDLE, all outputs 0 except req_ready_o = 1, no response.
